// File: rtl/prng_checker.sv
// Receive-side checker for the 32-bit LFSR byte generator (b[n] = b[n-1]^b[n-11]^b[n-31]^b[n-32]).
// Optional all-zero lock guard with output zero_det_o: define PRNG_CHK_ZERO_DET_EN.
module prng_checker #(
  parameter int GOOD_LIMIT = 2,
  parameter int ERR_LIMIT  = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             res_i,
  input  logic [7:0]       din_i,
  input  logic             din_valid_i,
  output logic             chk_valid_o,
  output logic             chk_err_o,
  output logic [3:0]       err_bits_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             locked_o,
  output logic             lost_lock_o
`ifdef PRNG_CHK_ZERO_DET_EN
  ,output logic            zero_det_o
`endif
);

  localparam int GW = $clog2(GOOD_LIMIT + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);

  typedef enum logic [1:0] {SYNC, VERIFY, LOCKED} state_t;

  state_t           state_q;
  logic [31:0]      hist_q;
  logic [1:0]       byte_cnt_q;
  logic [GW-1:0]    good_q;
  logic [EW-1:0]    bad_q;
  logic             chk_valid_q, chk_err_q, locked_q, lost_lock_q;
  logic [3:0]       err_bits_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic [31:0]      hist_d;
  logic [7:0]       mism;
  logic [3:0]       nbits;
  logic             pred_bit;
  logic [GW-1:0]    good_inc;
  logic [EW-1:0]    bad_inc;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_sat;

  // hist[0] is the newest bit; in LOCKED the prediction is fed back so line errors stay local
  always_comb begin
    hist_d   = hist_q;
    mism     = '0;
    nbits    = '0;
    pred_bit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      pred_bit = hist_d[0] ^ hist_d[10] ^ hist_d[30] ^ hist_d[31];
      mism[k]  = pred_bit ^ din_i[k];
      hist_d   = {hist_d[30:0], (state_q == LOCKED) ? pred_bit : din_i[k]};
      nbits    = nbits + 4'(mism[k]);
    end
  end

  assign good_inc = good_q + GW'(1);
  assign bad_inc  = bad_q + EW'(1);
  assign cnt_sum  = {1'b0, err_cnt_q} + (CNT_W+1)'(nbits);
  assign cnt_sat  = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

`ifdef PRNG_CHK_ZERO_DET_EN
  logic zero_det_q;
  assign zero_det_o = zero_det_q;
`endif

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state_q     <= SYNC;
      hist_q      <= '0;
      byte_cnt_q  <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      chk_valid_q <= 1'b0;
      chk_err_q   <= 1'b0;
      err_bits_q  <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      lost_lock_q <= 1'b0;
`ifdef PRNG_CHK_ZERO_DET_EN
      zero_det_q  <= 1'b0;
`endif
    end else begin
      chk_valid_q <= 1'b0;
      lost_lock_q <= 1'b0;
      if (din_valid_i) begin
        hist_q <= hist_d;
`ifdef PRNG_CHK_ZERO_DET_EN
        if (hist_d != '0) zero_det_q <= 1'b0;
`endif
        case (state_q)
          SYNC: begin
            chk_err_q  <= 1'b0;
            err_bits_q <= '0;
            if (byte_cnt_q == 2'd3) begin
`ifdef PRNG_CHK_ZERO_DET_EN
              // Counter parks at 3 so every further byte re-tests the history
              if (hist_d == '0) begin
                zero_det_q <= 1'b1;
              end else begin
                state_q <= VERIFY;
                good_q  <= '0;
              end
`else
              state_q <= VERIFY;
              good_q  <= '0;
`endif
            end else begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
          VERIFY: begin
            chk_valid_q <= 1'b1;
            chk_err_q   <= |mism;
            err_bits_q  <= nbits;
            if (|mism) begin
              state_q    <= SYNC;
              byte_cnt_q <= 2'd1;
              good_q     <= '0;
            end else if (good_inc == GW'(GOOD_LIMIT)) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              bad_q    <= '0;
            end else begin
              good_q <= good_inc;
            end
          end
          default: begin
            chk_valid_q <= 1'b1;
            chk_err_q   <= |mism;
            err_bits_q  <= nbits;
            if (|mism) begin
              err_cnt_q <= cnt_sat;
              if (bad_inc == EW'(ERR_LIMIT)) begin
                state_q     <= SYNC;
                locked_q    <= 1'b0;
                lost_lock_q <= 1'b1;
                byte_cnt_q  <= '0;
                bad_q       <= '0;
              end else begin
                bad_q <= bad_inc;
              end
            end else begin
              bad_q <= '0;
            end
          end
        endcase
      end
    end
  end

  assign chk_valid_o = chk_valid_q;
  assign chk_err_o   = chk_err_q;
  assign err_bits_o  = err_bits_q;
  assign err_cnt_o   = err_cnt_q;
  assign locked_o    = locked_q;
  assign lost_lock_o = lost_lock_q;

endmodule
